attopu_ctrl: RTL

Multi-cycle control unit for the attopu core. It fetches instructions over a valid/ready handshake and decodes them with a generalised field layout. It sequences single-cycle ALU and immediate ops, multi-cycle memory loads and stores with a req/ack handshake, and branches on flags it latches itself. It sits between instruction memory and the datapath (register file, ALU, PC, data memory), replacing the purely combinational decoder.

---
 rtl/attopu_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/attopu_ctrl.sv
// attopu_ctrl -- multi-cycle control unit for the attopu core.
//
// Fetches one instruction word into an internal IR, decodes it and drives
// the datapath strobes for one EXEC cycle. Memory ops add MEM cycles until
// mem_ack arrives. Branches test the C/Z flags latched by an earlier ALU op.
//
// Handshakes:
//   instr_valid/instr_ready: a word is taken on a rising edge where both are
//     high. instr_ready is high only in FETCH. instr_valid is ignored in
//     every other state.
//   mem_req/mem_ack: mem_req stays high through every MEM cycle. The access
//     completes on the edge where mem_ack is high. mem_ack is ignored outside
//     MEM.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid, instr      instruction word offered by instruction memory
//   instr_ready             control is in FETCH
//   alu_c, alu_z            ALU flags for the current cycle
//   c_flag, z_flag          latched flags
//   mem_req, mem_ack, memWE data memory handshake and write qualifier
//   dAddrSel                data address comes from the register file
//   regDataInSource         writeback data comes from memory
//   immData                 writeback data comes from addr
//   regFileWE               register-file write strobe
//   regInSel, regOutSel1/2  register selects (continuously from IR)
//   aluOp                   ALU op field (continuously from IR)
//   addr                    extended address/immediate, 0 when unused
//   pc_we, nextPCSel        PC update strobe and source (00 PC+1, 01 addr)
//   halt, resume            halted indication and halt exit request
//   dbgState                current FSM state
//
// Build option: define ATTOPU_HALT_RESUME_EN to let resume leave HALT.
// Without it, HALT exits only through reset.

module attopu_ctrl #(
    parameter int IW      = 16,
    parameter int RSEL_W  = 2,
    parameter int ALUOP_W = 7,
    parameter int AW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [IW-1:0]      instr,
    output logic               instr_ready,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic               c_flag,
    output logic               z_flag,
    output logic               mem_req,
    input  logic               mem_ack,
    output logic               memWE,
    output logic               dAddrSel,
    output logic               regDataInSource,
    output logic               immData,
    output logic               regFileWE,
    output logic [RSEL_W-1:0]  regInSel,
    output logic [RSEL_W-1:0]  regOutSel1,
    output logic [RSEL_W-1:0]  regOutSel2,
    output logic [ALUOP_W-1:0] aluOp,
    output logic [AW-1:0]      addr,
    output logic               pc_we,
    output logic [1:0]         nextPCSel,
    output logic               halt,
    input  logic               resume,
    output logic [1:0]         dbgState
);

    localparam int AFW = IW - 3 - RSEL_W;

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDX = 3'b011;
    localparam logic [2:0] OP_STX = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [IW-1:0]   ir;
    logic            loadIr;
    logic            latchFlags;

    logic [2:0]      opcode;
    logic [AFW-1:0]  absAddr;
    logic            brFlagSel;
    logic            brFlag;
    logic            brTaken;
    logic [AW-1:0]   addrZext;
    logic [AW-1:0]   addrSext;

    assign opcode     = ir[IW-1 -: 3];
    assign absAddr    = ir[AFW-1:0];
    assign brFlagSel  = ir[IW-4];
    assign brFlag     = ir[IW-5];
    assign regInSel   = ir[IW-4 -: RSEL_W];
    assign regOutSel1 = ir[IW-4-RSEL_W -: RSEL_W];
    assign regOutSel2 = ir[IW-4-2*RSEL_W -: RSEL_W];
    assign aluOp      = ir[ALUOP_W-1:0];
    assign dbgState   = state;

    // Branch condition uses only the latched flags, never this cycle's ALU flags.
    assign brTaken  = ((brFlagSel ? z_flag : c_flag) == brFlag);
    assign addrZext = AW'(absAddr);
    assign addrSext = AW'($signed(absAddr));

`ifndef ATTOPU_HALT_RESUME_EN
    logic unusedResume;
    assign unusedResume = resume;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            ir     <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            state <= stateNext;
            if (loadIr) begin
                ir <= instr;
            end
            if (latchFlags) begin
                c_flag <= alu_c;
                z_flag <= alu_z;
            end
        end
    end

    // All combinational outputs are forced low while reset is asserted, so
    // an in-flight memory request drops without waiting for a clock edge.
    always_comb begin
        stateNext       = state;
        loadIr          = 1'b0;
        latchFlags      = 1'b0;
        instr_ready     = 1'b0;
        mem_req         = 1'b0;
        memWE           = 1'b0;
        dAddrSel        = 1'b0;
        regDataInSource = 1'b0;
        immData         = 1'b0;
        regFileWE       = 1'b0;
        addr            = '0;
        pc_we           = 1'b0;
        nextPCSel       = 2'b00;
        halt            = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        loadIr    = 1'b1;
                        stateNext = EXEC;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_ALU: begin
                            regFileWE  = 1'b1;
                            latchFlags = 1'b1;
                            pc_we      = 1'b1;
                            stateNext  = FETCH;
                        end
                        OP_LDI: begin
                            immData   = 1'b1;
                            regFileWE = 1'b1;
                            addr      = addrZext;
                            pc_we     = 1'b1;
                            stateNext = FETCH;
                        end
                        OP_LDX, OP_STX: begin
                            stateNext = MEM;
                        end
                        OP_BR: begin
                            pc_we = 1'b1;
                            if (brTaken) begin
                                nextPCSel = 2'b01;
                                addr      = addrSext;
                            end
                            stateNext = FETCH;
                        end
                        OP_HLT: begin
                            stateNext = HALT;
                        end
                        default: begin
                            pc_we     = 1'b1;
                            stateNext = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    dAddrSel = 1'b1;
                    // Only LD ind and ST ind reach MEM, so opcode splits them.
                    if (opcode == OP_STX) begin
                        memWE = 1'b1;
                    end else begin
                        regDataInSource = 1'b1;
                    end
                    if (mem_ack) begin
                        regFileWE = (opcode != OP_STX);
                        pc_we     = 1'b1;
                        stateNext = FETCH;
                    end
                end
                HALT: begin
                    halt = 1'b1;
`ifdef ATTOPU_HALT_RESUME_EN
                    if (resume) begin
                        pc_we     = 1'b1;
                        stateNext = FETCH;
                    end
`endif
                end
                default: begin
                    stateNext = FETCH;
                end
            endcase
        end
    end

endmodule
